// File: rtl/check_node_pkg.sv
// Shared widths, empty-cell constant, FSM encoding and cell record for the check-node sorted list.
package check_node_pkg;

  localparam int CNS_WIDTH    = 5;
  localparam int CNS_DW       = CNS_WIDTH + 1;
  localparam int CNS_SYM_BITS = 6;
  localparam int CNS_DEPTH    = 16;

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } cns_state_e;

  typedef struct packed {
    logic                    occ;
    logic [CNS_DW-1:0]       data;
    logic [CNS_SYM_BITS-1:0] sym;
  } cell_t;

  localparam cell_t CNS_EMPTY_CELL = {1'b0, {CNS_DW{1'b1}}, {CNS_SYM_BITS{1'b0}}};

  function automatic cell_t cns_make_cell(input logic [CNS_DW-1:0] data,
                                          input logic [CNS_SYM_BITS-1:0] sym);
    cell_t c;
    c.occ  = 1'b1;
    c.data = data;
    c.sym  = sym;
    return c;
  endfunction

endpackage

// File: rtl/check_node_sorted_list_if.sv
// Input and output valid/ready streams of the check-node sorted list.
interface check_node_sorted_list_if #(
  parameter int WIDTH    = check_node_pkg::CNS_WIDTH,
  parameter int SYM_BITS = check_node_pkg::CNS_SYM_BITS
) ();

  logic                in_valid;
  logic                in_ready;
  logic [WIDTH:0]      in_data;
  logic [SYM_BITS-1:0] in_sym;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH:0]      out_data;
  logic [SYM_BITS-1:0] out_sym;
  logic                out_last;

  modport master (
    output in_valid, in_data, in_sym, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sym, out_last
  );

  modport slave (
    input  in_valid, in_data, in_sym, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sym, out_last
  );

endinterface

// File: rtl/check_node_cmp.sv
// Check-node comparator: input strictly below the cell value, with an empty cell always losing.
module check_node_cmp
  import check_node_pkg::*;
(
  input  logic [CNS_DW-1:0] i_a,
  input  logic [CNS_DW-1:0] i_b,
  input  logic              i_b_valid,
  output logic              o_lt
);

  assign o_lt = !i_b_valid || (i_a < i_b);

endmodule

// File: rtl/check_node_sort_cell.sv
// One sorted-list cell: holds, takes the input, takes its left neighbour (insert) or its right one (drain).
module check_node_sort_cell
  import check_node_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_ins_en,
  input  logic                    i_shift_en,
  input  logic [CNS_DW-1:0]       i_in_data,
  input  logic [CNS_SYM_BITS-1:0] i_in_sym,
  input  logic                    i_lt_left,
  input  cell_t                   i_left,
  input  cell_t                   i_right,
  output logic                    o_lt,
  output cell_t                   o_cell
);

  cell_t r_cell;
  cell_t w_cell_nxt;
  logic  w_lt;

  check_node_cmp u_cmp (
    .i_a       (i_in_data),
    .i_b       (r_cell.data),
    .i_b_valid (r_cell.occ),
    .o_lt      (w_lt)
  );

  // Next cell value; the leftmost cell whose lt is set takes the input, the rest shift right.
  always_comb begin
    w_cell_nxt = r_cell;
    if (i_ins_en) begin
      if (w_lt && i_lt_left) begin
        w_cell_nxt = i_left;
      end else if (w_lt) begin
        w_cell_nxt = cns_make_cell(i_in_data, i_in_sym);
      end else begin
        w_cell_nxt = r_cell;
      end
    end else if (i_shift_en) begin
      w_cell_nxt = i_right;
    end else begin
      w_cell_nxt = r_cell;
    end
  end

  // Cell register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cell <= CNS_EMPTY_CELL;
    end else begin
      r_cell <= w_cell_nxt;
    end
  end

  assign o_lt   = w_lt;
  assign o_cell = r_cell;

endmodule

// File: rtl/check_node_sorted_list.sv
// Insertion-sorted list keeping the DEPTH most reliable (reliability, symbol) pairs of a frame.
// Optional CNS_DROP_COUNT_EN adds o_drop_count, the saturating per-frame discard count.
module check_node_sorted_list
  import check_node_pkg::*;
#(
  parameter int WIDTH    = CNS_WIDTH,
  parameter int SYM_BITS = CNS_SYM_BITS,
  parameter int DEPTH    = CNS_DEPTH
) (
  input  logic i_clk,
  input  logic i_rst_n,
  check_node_sorted_list_if.slave bus
`ifdef CNS_DROP_COUNT_EN
  ,
  output logic [7:0] o_drop_count
`endif
);

  cns_state_e          r_state;
  cns_state_e          w_state_nxt;
  logic                w_ins_en;
  logic                w_shift_en;
  logic                w_in_ready;
  logic                w_out_valid;
  logic                w_out_last;
  logic [WIDTH:0]      w_in_data;
  logic [SYM_BITS-1:0] w_in_sym;
  logic [DEPTH-1:0]    w_lt;
  cell_t               w_cell [DEPTH];
  logic                w_lt_tail_unused;

  assign w_in_data        = bus.in_data;
  assign w_in_sym         = bus.in_sym;
  assign w_lt_tail_unused = w_lt[DEPTH-1];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
    cell_t w_left;
    cell_t w_right;
    logic  w_lt_left;

    if (gi == 0) begin : g_head
      assign w_left    = CNS_EMPTY_CELL;
      assign w_lt_left = 1'b0;
    end else begin : g_body
      assign w_left    = w_cell[gi-1];
      assign w_lt_left = w_lt[gi-1];
    end

    // The tail refills with an empty cell as the list drains towards the head.
    if (gi == DEPTH - 1) begin : g_tail
      assign w_right = CNS_EMPTY_CELL;
    end else begin : g_inner
      assign w_right = w_cell[gi+1];
    end

    check_node_sort_cell u_cell (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_ins_en   (w_ins_en),
      .i_shift_en (w_shift_en),
      .i_in_data  (w_in_data),
      .i_in_sym   (w_in_sym),
      .i_lt_left  (w_lt_left),
      .i_left     (w_left),
      .i_right    (w_right),
      .o_lt       (w_lt[gi]),
      .o_cell     (w_cell[gi])
    );
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus insert/shift enables and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_ins_en    = 1'b0;
    w_shift_en  = 1'b0;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_out_last  = 1'b0;
    case (r_state)
      ST_FILL: begin
        w_in_ready = 1'b1;
        w_ins_en   = bus.in_valid;
        if (bus.in_valid && bus.in_last) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_FILL;
        end
      end
      ST_DRAIN: begin
        w_out_valid = w_cell[0].occ;
        w_out_last  = w_cell[0].occ && !w_cell[1].occ;
        w_shift_en  = w_out_valid && bus.out_ready;
        // An empty head in DRAIN cannot occur normally; leaving avoids a dead lock.
        if (w_shift_en && w_out_last) begin
          w_state_nxt = ST_FILL;
        end else if (!w_cell[0].occ) begin
          w_state_nxt = ST_FILL;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_FILL;
      end
    endcase
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_cell[0].data;
  assign bus.out_sym   = w_cell[0].sym;
  assign bus.out_last  = w_out_last;

`ifdef CNS_DROP_COUNT_EN
  logic       w_accept;
  logic [7:0] r_drop_count;

  assign w_accept = (r_state == ST_FILL) && bus.in_valid;

  // A full tail means every accepted beat costs one entry: either the evicted tail or the input itself.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_drop_count <= 8'd0;
    end else if (w_accept && !w_cell[0].occ) begin
      r_drop_count <= 8'd0;
    end else if (w_accept && w_cell[DEPTH-1].occ && (r_drop_count != 8'hFF)) begin
      r_drop_count <= r_drop_count + 8'd1;
    end else begin
      r_drop_count <= r_drop_count;
    end
  end

  assign o_drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_check_node_sorted_list.sv
// Directed self-checking bench for check_node_sorted_list (checks o_drop_count when CNS_DROP_COUNT_EN is set).
module tb_check_node_sorted_list;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [5:0] fd [32];
  logic [5:0] fs [32];
  logic [5:0] ed [32];
  logic [5:0] es [32];

  always #5 clk = ~clk;

  check_node_sorted_list_if #(.WIDTH(5), .SYM_BITS(6)) bus ();

`ifdef CNS_DROP_COUNT_EN
  logic [7:0] drop_count;
`endif

  check_node_sorted_list #(.WIDTH(5), .SYM_BITS(6), .DEPTH(16)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
`ifdef CNS_DROP_COUNT_EN
    ,
    .o_drop_count (drop_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives n beats starting on a negedge; each beat is accepted on the following posedge.
  task automatic send_frame(input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = fd[i];
      bus.in_sym   = fs[i];
      bus.in_last  = with_last && (i == n - 1);
      check("in_ready_fill", {31'd0, bus.in_ready}, 32'd1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Drains n expected entries; stall applies the ready pattern 1,0,0,1; poke drives a bogus input beat.
  task automatic drain(input int n, input bit stall, input bit poke);
    int idx = 0;
    int cyc = 0;
    bit rdy;
    bus.in_valid = poke;
    bus.in_data  = 6'd0;
    bus.in_sym   = 6'd0;
    bus.in_last  = 1'b0;
    while (idx < n && cyc < 100) begin
      rdy = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      bus.out_ready = rdy;
      check("in_ready_drain", {31'd0, bus.in_ready}, 32'd0);
      check("out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("out_data", {26'd0, bus.out_data}, {26'd0, ed[idx]});
      check("out_sym", {26'd0, bus.out_sym}, {26'd0, es[idx]});
      check("out_last", {31'd0, bus.out_last}, (idx == n - 1) ? 32'd1 : 32'd0);
      if (rdy) idx++;
      @(negedge clk);
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("drain_count", idx, n);
    check("in_ready_after", {31'd0, bus.in_ready}, 32'd1);
    check("out_valid_after", {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 6'd0;
    bus.in_sym    = 6'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data", {26'd0, bus.out_data}, 32'd63);
    check("rst_out_sym", {26'd0, bus.out_sym}, 32'd0);
    check("rst_out_last", {31'd0, bus.out_last}, 32'd0);
`ifdef CNS_DROP_COUNT_EN
    check("rst_drop", {24'd0, drop_count}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Mixed frame with a tie; bogus input beats during drain must be ignored
    fd[0] = 6'd9; fd[1] = 6'd3; fd[2] = 6'd7; fd[3] = 6'd3; fd[4] = 6'd1;
    fs[0] = 6'd0; fs[1] = 6'd1; fs[2] = 6'd2; fs[3] = 6'd5; fs[4] = 6'd4;
    send_frame(5, 1'b1);
`ifdef CNS_DROP_COUNT_EN
    check("drop_t1", {24'd0, drop_count}, 32'd0);
`endif
    ed[0] = 6'd1; ed[1] = 6'd3; ed[2] = 6'd3; ed[3] = 6'd7; ed[4] = 6'd9;
    es[0] = 6'd4; es[1] = 6'd1; es[2] = 6'd5; es[3] = 6'd2; es[4] = 6'd0;
    drain(5, 1'b0, 1'b1);

    // 20 descending beats: the four largest are discarded
    for (int i = 0; i < 20; i++) begin
      fd[i] = 6'(19 - i);
      fs[i] = 6'(19 - i);
    end
    send_frame(20, 1'b1);
`ifdef CNS_DROP_COUNT_EN
    check("drop_t2", {24'd0, drop_count}, 32'd4);
`endif
    for (int i = 0; i < 16; i++) begin
      ed[i] = 6'(i);
      es[i] = 6'(i);
    end
    drain(16, 1'b0, 1'b0);
`ifdef CNS_DROP_COUNT_EN
    check("drop_t2_held", {24'd0, drop_count}, 32'd4);
`endif

    // 16 equal all-ones beats: full list, no discards, input order kept
    for (int i = 0; i < 16; i++) begin
      fd[i] = 6'd63;
      fs[i] = 6'(i);
      ed[i] = 6'd63;
      es[i] = 6'(i);
    end
    send_frame(16, 1'b1);
`ifdef CNS_DROP_COUNT_EN
    check("drop_t3", {24'd0, drop_count}, 32'd0);
`endif
    drain(16, 1'b0, 1'b0);

    // Drain with downstream stalls
    fd[0] = 6'd4; fd[1] = 6'd2; fd[2] = 6'd8; fd[3] = 6'd6;
    fs[0] = 6'd1; fs[1] = 6'd2; fs[2] = 6'd3; fs[3] = 6'd4;
    send_frame(4, 1'b1);
    ed[0] = 6'd2; ed[1] = 6'd4; ed[2] = 6'd6; ed[3] = 6'd8;
    es[0] = 6'd2; es[1] = 6'd1; es[2] = 6'd4; es[3] = 6'd3;
    drain(4, 1'b1, 1'b1);

    // Single-beat frame
    fd[0] = 6'd12; fs[0] = 6'd7;
    send_frame(1, 1'b1);
    ed[0] = 6'd12; es[0] = 6'd7;
    drain(1, 1'b0, 1'b0);

    // Reset in the middle of a frame discards it
    fd[0] = 6'd10; fd[1] = 6'd11; fd[2] = 6'd12;
    fs[0] = 6'd1;  fs[1] = 6'd2;  fs[2] = 6'd3;
    send_frame(3, 1'b0);
    rst_n = 1'b0;
    #2;
    check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_out_data", {26'd0, bus.out_data}, 32'd63);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    fd[0] = 6'd5; fs[0] = 6'd3;
    send_frame(1, 1'b1);
    ed[0] = 6'd5; es[0] = 6'd3;
    drain(1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/check_node_sorted_list.md
Name: check_node_sorted_list

Overview:
- Insertion-sorted register list that consumes per-cell "input < cell" comparison results in the non-binary LDPC check-node datapath.
- Accepts a frame of (reliability, GF symbol) pairs, one per cycle, and keeps the DEPTH smallest reliabilities in ascending order.
- On the frame's last beat it drains the list, smallest first, to the downstream check-node combiner over a valid/ready handshake.

Parameters:
- WIDTH, 5: MSB index of reliability data; data is WIDTH+1 bits.
- SYM_BITS, 6: GF symbol tag width (GF(64)).
- DEPTH, 16: number of list cells (n_m); must be at least 2.

Ports:
- Clk, input, 1: rising-edge clock.
- Rst_n, input, 1: asynchronous active-low reset.
- In_Valid, input, 1: input beat valid.
- In_Ready, output, 1: list accepts an input beat.
- In_Data, input, WIDTH+1: reliability (smaller = more reliable).
- In_Sym, input, SYM_BITS: GF symbol tag of the beat.
- In_Last, input, 1: final beat of the frame; qualified by In_Valid.
- Out_Valid, output, 1: output entry valid.
- Out_Ready, input, 1: downstream accepts the entry.
- Out_Data, output, WIDTH+1: reliability of the head cell.
- Out_Sym, output, SYM_BITS: symbol of the head cell.
- Out_Last, output, 1: current output is the last stored entry.

Behaviour:
- Reset values:
  - FSM = FILL.
  - All cell occupied flags = 0; cell data = all ones; cell symbols = 0.
  - In_Ready = 1.
  - Out_Valid = 0, Out_Data = all ones, Out_Sym = 0, Out_Last = 0.
- Comparison:
  - lt[i] = (In_Data < Cell_Data[i]), strict less-than.
  - An unoccupied cell forces lt[i] = 1.
  - Equal values therefore insert behind the existing entry, so ordering is stable.
- FILL state:
  - In_Ready = 1.
  - On In_Valid, for each cell i:
    - lt[i] and (i = 0 or !lt[i-1]): load the input into cell i and set its occupied flag.
    - lt[i] and lt[i-1]: load from cell i-1.
    - otherwise: hold.
  - The cell shifted out of position DEPTH-1 is discarded.
  - An input with lt[DEPTH-1] = 0 is discarded.
  - Throughput is one insertion per cycle with no bubbles. The result is visible in the cells the cycle after acceptance.
  - Accepting In_Last moves to DRAIN at the next edge. The In_Last beat itself is inserted.
- DRAIN state:
  - In_Ready = 0.
  - Out_Valid = occupied[0].
  - Out_Data and Out_Sym are the registered contents of cell 0.
  - Out_Last = occupied[0] and !occupied[1].
  - On Out_Valid and Out_Ready, every cell loads from cell i+1. Cell DEPTH-1 loads the empty value.
  - Handshake on Out_Last returns the FSM to FILL at the next edge. All cells are empty at that point.
  - Out_Data and Out_Sym must hold stable while Out_Valid = 1 and Out_Ready = 0.
- Boundary conditions:
  - Frame shorter than DEPTH: drain emits exactly the number of accepted beats.
  - Frame of exactly DEPTH beats: no discards.
  - Frame of N > DEPTH beats: drain emits the DEPTH smallest.
  - Every frame has at least one beat, because In_Last only arrives qualified by In_Valid.
  - Reset asserted mid-frame or mid-drain: immediately returns to the reset state and the partial frame is lost.
  - In_Valid in DRAIN is ignored (not accepted).

Optional Feature:
- Macro: CNS_DROP_COUNT_EN.
- When defined:
  - Adds output port Drop_Count, 8 bits.
  - Counts entries discarded in the current frame, both evicted entries and rejected inputs. Saturates at 255.
  - Clears to 0 on the first accepted beat of a frame.
  - Stable throughout DRAIN.
  - Resets to 0.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package check_node_pkg:
  - data and symbol widths;
  - empty-cell value constant (all ones);
  - FSM state encoding FILL/DRAIN;
  - cell record type (occupied flag, data, symbol).
- One sub-module, check_node_sort_cell:
  - holds one cell register;
  - instantiates the team's existing check-node comparator for lt[i];
  - muxes hold, load-input, load-from-left and load-from-right.
- The top level instantiates DEPTH cells plus the FSM and output logic.

Test Plan:
- Reset then frame {9,3,7,3(sym 5),1, last}, syms {0,1,2,5,4}, Out_Ready=1 -> drains 1/4, 3/1, 3/5, 7/2, 9/0; Out_Last on 9/0 only.
- DEPTH=16, frame of 20 beats valued 19 down to 0 -> drains 0..15 ascending; Drop_Count=4 with the macro defined.
- Frame of 16 beats all value 63 -> 16 entries out in input order (stable ties); Drop_Count=0.
- Drain with Out_Ready toggling 1,0,0,1 -> each entry emitted exactly once; outputs held during stalls; In_Ready=0 throughout DRAIN.
- Single-beat frame (value 12, In_Last=1) -> one output, 12, with Out_Last=1; back in FILL next cycle with In_Ready=1.
- Rst_n pulsed low after 3 beats of a frame, then new frame {5,last} -> only 5 is drained; no residue from the aborted frame.
